fpu_poly_horner_seq: RTL and testbench
======================================

# fpu_poly_horner_seq

Sequencer that evaluates the FPU transcendental approximation polynomials (F2XM1, LOG2) by Horner's method. It walks the polynomial coefficient ROM from the highest index down and issues alternating multiply/add operations to the shared FP80 arithmetic unit over a request/done handshake. It returns the FP80 result with a one-cycle done pulse. It sits between the transcendental microsequencer, which requests an evaluation, and the coefficient ROM plus the shared add/mul datapath.

## Interface
- No parameters. Top coefficient index is fixed per polynomial: F2XM1 (select 0) = 5, LOG2 (select 1) = 7.
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- poly_select  in  4  polynomial selector (0 = F2XM1, 1 = LOG2)
- x_in  in  80  FP80 argument; latched on accepted start
- rom_poly_select  out  4  registered selector to the coefficient ROM
- rom_coeff_index  out  4  registered coefficient index to the ROM
- rom_coefficient  in  80  combinational ROM data for the current index
- arith_req  out  1  one-cycle operation request
- arith_op  out  1  0 = add (a+b), 1 = multiply (a*b)
- arith_a, arith_b  out  80 each  operands
- arith_done  in  1  one-cycle completion pulse from the arithmetic unit
- arith_result  in  80  result, valid while arith_done = 1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  unsupported poly_select; valid with done
- result  out  80  final value; held until the next accepted start

## Operation
- Algorithm for top index n:
  - acc = c[n]
  - for i = n-1 down to 0: acc = acc*x, then acc = acc + c[i]
  - finally acc = acc*x
- F2XM1 issues 6 multiplies and 5 adds. LOG2 issues 8 multiplies and 7 adds.
- IDLE:
  - start=1 with poly_select ∈ {0,1}: latch x_in and poly_select, set rom_coeff_index = n, go to LOAD.
  - start=1 with any other poly_select: go to DONE with error=1 and result=0. No arith_req is issued.
- LOAD: acc <= rom_coefficient; rom_coeff_index <= n-1; go to MUL_REQ.
- MUL_REQ: arith_req=1, op=1, a=acc, b=x; go to MUL_WAIT.
- MUL_WAIT: on arith_done, acc <= arith_result and go to ADD_REQ.
- ADD_REQ: arith_req=1, op=0, a=acc, b=rom_coefficient; go to ADD_WAIT.
- ADD_WAIT: on arith_done, acc <= arith_result. Then:
  - rom_coeff_index == 0: go to FMUL_REQ.
  - otherwise: decrement the index and go to MUL_REQ.
- FMUL_REQ / FMUL_WAIT: same as MUL_REQ / MUL_WAIT. On done, result <= arith_result and go to DONE.
- DONE: done=1 for one cycle; error reflects the run; return to IDLE.
- arith_op, arith_a and arith_b are held stable from the REQ cycle until the cycle arith_done is sampled.
- arith_done is sampled only in WAIT states and is ignored in all other states.
- start while busy is ignored and is not queued.
- The block does no FP arithmetic itself; operands and results pass through unmodified.

## Timing
- Reset values:
  - state = IDLE
  - busy, done, error, arith_req, arith_op = 0
  - arith_a, arith_b, result, acc = 0
  - rom_poly_select, rom_coeff_index = 0
- Reset asserted in any state returns to IDLE the next cycle with the values above. An in-flight arith_done arriving after reset is ignored.
- Latency with zero-wait arithmetic (arith_done the cycle after arith_req): done asserts 4n+4 cycles after the cycle in which start is accepted.
  - F2XM1: 24 cycles.
  - LOG2: 32 cycles.
  - Each extra wait cycle per operation adds 1 to the total.
- Unsupported selector: done 1 cycle after start.
- A new start is accepted in the cycle after done (IDLE).

## Test plan
- F2XM1 with x=3FFF_8000000000000000 (1.0) and a zero-wait behavioural arithmetic model:
  - first arith_req is op=1, a=3FF3_A27912F3B25C65D8, b=x;
  - first add has b=3FF6_AE64567F544E3897;
  - 6 muls and 5 adds total; done at start+24; result matches the model.
- LOG2 with x=3FFE_8000000000000000 (0.5):
  - ROM indices 7..0 are visited in order;
  - 8 muls and 7 adds; done at start+32; result equals the model's Horner value.
- poly_select=2, start:
  - done with error=1 and result=0 one cycle later;
  - arith_req never asserts; busy high for exactly 1 cycle.
- Arithmetic unit stalls 10 cycles per operation:
  - arith_req is one cycle per operation;
  - operands are stable until done;
  - F2XM1 latency is 24+110=134.
- start pulsed while busy mid-F2XM1: ignored; exactly one done pulse; result unchanged by the second start.
- reset asserted in ADD_WAIT, then a stray arith_done: all outputs return to reset values; the stray done is ignored; a subsequent F2XM1 run completes normally in 24 cycles.

Source files
------------

// File: rtl/fpu_poly_horner_seq.sv
// Horner-method polynomial sequencer for the FPU transcendental unit.
// Walks the coefficient ROM from the top index down to zero and drives the
// shared FP80 add/mul unit with alternating multiply/add requests.
// Operands and results pass through unmodified; no arithmetic is done here.
//
// Arithmetic handshake: arith_req is a one-cycle pulse in a *_REQ state;
// arith_op/arith_a/arith_b stay stable from that cycle until the cycle in
// which arith_done is sampled (only *_WAIT states sample arith_done; a
// pulse seen in any other state is ignored).
module fpu_poly_horner_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  poly_select,
    input  logic [79:0] x_in,
    output logic [3:0]  rom_poly_select,
    output logic [3:0]  rom_coeff_index,
    input  logic [79:0] rom_coefficient,
    output logic        arith_req,
    output logic        arith_op,
    output logic [79:0] arith_a,
    output logic [79:0] arith_b,
    input  logic        arith_done,
    input  logic [79:0] arith_result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [79:0] result,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_MUL_REQ   = 4'd2,
        S_MUL_WAIT  = 4'd3,
        S_ADD_REQ   = 4'd4,
        S_ADD_WAIT  = 4'd5,
        S_FMUL_REQ  = 4'd6,
        S_FMUL_WAIT = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [79:0] acc;
    logic [79:0] x_reg;
    logic        err_reg;
    logic        sel_ok;
    logic [3:0]  top_index;

    // Only F2XM1 (0) and LOG2 (1) have coefficient tables.
    assign sel_ok    = (poly_select == 4'd0) || (poly_select == 4'd1);
    assign top_index = (poly_select == 4'd1) ? 4'd7 : 4'd5;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one mul/add pair per coefficient, then a final mul.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = sel_ok ? S_LOAD : S_DONE;
            S_LOAD:      state_nxt = S_MUL_REQ;
            S_MUL_REQ:   state_nxt = S_MUL_WAIT;
            S_MUL_WAIT:  if (arith_done) state_nxt = S_ADD_REQ;
            S_ADD_REQ:   state_nxt = S_ADD_WAIT;
            S_ADD_WAIT:  if (arith_done) state_nxt = (rom_coeff_index == 4'd0) ? S_FMUL_REQ : S_MUL_REQ;
            S_FMUL_REQ:  state_nxt = S_FMUL_WAIT;
            S_FMUL_WAIT: if (arith_done) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: argument, accumulator, ROM address, final result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc             <= 80'd0;
            x_reg           <= 80'd0;
            result          <= 80'd0;
            err_reg         <= 1'b0;
            rom_poly_select <= 4'd0;
            rom_coeff_index <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            x_reg           <= x_in;
                            rom_poly_select <= poly_select;
                            rom_coeff_index <= top_index;
                            err_reg         <= 1'b0;
                        end else begin
                            err_reg <= 1'b1;
                            result  <= 80'd0;
                        end
                    end
                end
                S_LOAD: begin
                    acc             <= rom_coefficient;
                    rom_coeff_index <= rom_coeff_index - 4'd1;
                end
                S_MUL_WAIT: begin
                    if (arith_done) acc <= arith_result;
                end
                S_ADD_WAIT: begin
                    if (arith_done) begin
                        acc <= arith_result;
                        if (rom_coeff_index != 4'd0) rom_coeff_index <= rom_coeff_index - 4'd1;
                    end
                end
                S_FMUL_WAIT: begin
                    if (arith_done) begin
                        acc    <= arith_result;
                        result <= arith_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; operands are gated to zero outside operations.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        error     = (state == S_DONE) && err_reg;
        arith_req = (state == S_MUL_REQ) || (state == S_ADD_REQ) || (state == S_FMUL_REQ);
        arith_op  = 1'b0;
        arith_a   = 80'd0;
        arith_b   = 80'd0;
        case (state)
            S_MUL_REQ, S_MUL_WAIT, S_FMUL_REQ, S_FMUL_WAIT: begin
                arith_op = 1'b1;
                arith_a  = acc;
                arith_b  = x_reg;
            end
            S_ADD_REQ, S_ADD_WAIT: begin
                arith_op = 1'b0;
                arith_a  = acc;
                arith_b  = rom_coefficient;
            end
            default: ;
        endcase
        state_dbg = state;
    end

endmodule

// File: tb/tb_fpu_poly_horner_seq.sv
// Bench for fpu_poly_horner_seq: behavioural ROM and arithmetic unit
// (integer add/mul modulo 2^80 stand in for FP80), a Horner reference model,
// table vectors, randomized runs and hand-written corner sequences.
module tb_fpu_poly_horner_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  poly_select = 4'd0;
    logic [79:0] x_in = 80'd0;
    logic [3:0]  rom_poly_select;
    logic [3:0]  rom_coeff_index;
    logic [79:0] rom_coefficient;
    logic        arith_req;
    logic        arith_op;
    logic [79:0] arith_a;
    logic [79:0] arith_b;
    logic        arith_done = 1'b0;
    logic [79:0] arith_result = 80'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic [79:0] result;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad = 0;

    fpu_poly_horner_seq dut (
        .clk(clk), .reset(reset), .start(start), .poly_select(poly_select), .x_in(x_in),
        .rom_poly_select(rom_poly_select), .rom_coeff_index(rom_coeff_index),
        .rom_coefficient(rom_coefficient), .arith_req(arith_req), .arith_op(arith_op),
        .arith_a(arith_a), .arith_b(arith_b), .arith_done(arith_done),
        .arith_result(arith_result), .busy(busy), .done(done), .error(error),
        .result(result), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- coefficient ROM ----------------
    logic [79:0] coef_f [0:5];
    logic [79:0] coef_l [0:7];

    always_comb begin
        rom_coefficient = 80'd0;
        if (rom_poly_select == 4'd0 && rom_coeff_index <= 4'd5) rom_coefficient = coef_f[rom_coeff_index];
        else if (rom_poly_select == 4'd1 && rom_coeff_index <= 4'd7) rom_coefficient = coef_l[rom_coeff_index];
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [79:0] horner(input logic [3:0] sel, input logic [79:0] x);
        logic [79:0] acc;
        int n;
        n = (sel == 4'd1) ? 7 : 5;
        acc = (sel == 4'd1) ? coef_l[n] : coef_f[n];
        for (int i = n - 1; i >= 0; i--) begin
            acc = acc * x;
            acc = acc + ((sel == 4'd1) ? coef_l[i] : coef_f[i]);
        end
        acc = acc * x;
        return acc;
    endfunction

    function automatic logic [79:0] rand80();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        return {c[15:0], b, a};
    endfunction

    // ---------------- behavioural arithmetic unit ----------------
    int          stall = 0;
    bit          pending = 0;
    int          pend_cnt = 0;
    logic        pend_op;
    logic [79:0] pend_a;
    logic [79:0] pend_b;
    logic [79:0] pend_res;
    bit          inject_stray = 0;
    int          n_mul = 0;
    int          n_add = 0;
    logic        op_q [$];
    logic [79:0] a_q [$];
    logic [79:0] b_q [$];
    logic [3:0]  idx_q [$];

    always @(negedge clk) begin
        arith_done = 1'b0;
        if (pending) begin
            chk("req_single_cycle", {79'd0, arith_req}, 80'd0);
            chk("op_stable", {79'd0, arith_op}, {79'd0, pend_op});
            chk("a_stable", arith_a, pend_a);
            chk("b_stable", arith_b, pend_b);
            if (pend_cnt == 0) begin
                arith_done   = 1'b1;
                arith_result = pend_res;
                pending      = 0;
            end else begin
                pend_cnt--;
            end
        end else if (inject_stray) begin
            arith_done   = 1'b1;
            arith_result = rand80();
            inject_stray = 0;
        end
        if (arith_req && !pending) begin
            pending  = 1;
            pend_cnt = stall;
            pend_op  = arith_op;
            pend_a   = arith_a;
            pend_b   = arith_b;
            pend_res = arith_op ? arith_a * arith_b : arith_a + arith_b;
            op_q.push_back(arith_op);
            a_q.push_back(arith_a);
            b_q.push_back(arith_b);
            if (arith_op) n_mul++;
            else n_add++;
        end
        if (busy && (idx_q.size() == 0 || idx_q[$] != rom_coeff_index)) idx_q.push_back(rom_coeff_index);
    end

    // ---------------- driver ----------------
    task automatic run(input logic [3:0] sel, input logic [79:0] x, input int st,
                       output int lat, output logic [79:0] res, output logic err);
        stall = st;
        n_mul = 0;
        n_add = 0;
        op_q.delete();
        a_q.delete();
        b_q.delete();
        idx_q.delete();
        @(negedge clk);
        start = 1'b1;
        poly_select = sel;
        x_in = x;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 3000) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!done) chk("done_timeout", {79'd0, done}, 80'd1);
        res = result;
        err = error;
        @(posedge clk);
        #1;
        chk("done_one_cycle", {79'd0, done}, 80'd0);
        chk("idle_after_done", {79'd0, busy}, 80'd0);
    endtask

    function automatic int exp_latency(input logic [3:0] sel, input int st);
        int n;
        if (sel > 4'd1) return 1;
        n = (sel == 4'd1) ? 7 : 5;
        return 4 * n + 4 + (2 * n + 1) * st;
    endfunction

    task automatic check_run(input string tag, input logic [3:0] sel, input logic [79:0] x, input int st);
        int          lat;
        logic [79:0] res;
        logic        err;
        logic        bad_sel;
        int          n;
        bad_sel = (sel > 4'd1);
        n = (sel == 4'd1) ? 7 : 5;
        run(sel, x, st, lat, res, err);
        chk({tag, "_latency"}, lat, exp_latency(sel, st));
        chk({tag, "_error"}, {79'd0, err}, {79'd0, bad_sel});
        chk({tag, "_result"}, res, bad_sel ? 80'd0 : horner(sel, x));
        chk({tag, "_muls"}, n_mul, bad_sel ? 0 : n + 1);
        chk({tag, "_adds"}, n_add, bad_sel ? 0 : n);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [79:0] x;
        int          st;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat;
        logic [79:0] res;
        logic        err;
        int          cyc;
        int          n_done;
        int          first_done;
        logic [79:0] x1;

        coef_f[0] = 80'h3FFE_B17217F7D1CF79AC;
        coef_f[1] = 80'h3FFC_F5FDEFFC162C7543;
        coef_f[2] = 80'h3FFA_E35846B82505FC5A;
        coef_f[3] = 80'h3FF8_9D955B7DD273B94E;
        coef_f[4] = 80'h3FF6_AE64567F544E3897;
        coef_f[5] = 80'h3FF3_A27912F3B25C65D8;
        coef_l[0] = 80'h4000_B8AA3B295C17F0BC;
        coef_l[1] = 80'h3FFE_F6384EE1D01FEBA5;
        coef_l[2] = 80'h3FFD_93BB62877CDFF3C9;
        coef_l[3] = 80'h3FFC_D30BB153D6F6C9FB;
        coef_l[4] = 80'h3FFC_A42589EBE0193A48;
        coef_l[5] = 80'h3FFB_86779EC3E4ED1A81;
        coef_l[6] = 80'h3FFA_E6AF3F2C3D4B8F21;
        coef_l[7] = 80'h3FFA_9E0C7C0D6A5B2E33;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {79'd0, busy}, 80'd0);
        chk("rst_done", {79'd0, done}, 80'd0);
        chk("rst_error", {79'd0, error}, 80'd0);
        chk("rst_req", {79'd0, arith_req}, 80'd0);
        chk("rst_result", result, 80'd0);
        chk("rst_rom_idx", {76'd0, rom_coeff_index}, 80'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---- F2XM1, x = 1.0: first request operands and first add ----
        check_run("f2xm1_one", 4'd0, 80'h3FFF_8000000000000000, 0);
        chk("f2xm1_first_op", {79'd0, op_q[0]}, 80'd1);
        chk("f2xm1_first_a", a_q[0], 80'h3FF3_A27912F3B25C65D8);
        chk("f2xm1_first_b", b_q[0], 80'h3FFF_8000000000000000);
        chk("f2xm1_first_add_op", {79'd0, op_q[1]}, 80'd0);
        chk("f2xm1_first_add_b", b_q[1], 80'h3FF6_AE64567F544E3897);

        // ---- LOG2, x = 0.5: ROM index walk ----
        check_run("log2_half", 4'd1, 80'h3FFE_8000000000000000, 0);
        chk("log2_idx_count", idx_q.size(), 8);
        for (int i = 0; i < idx_q.size() && i < 8; i++) chk("log2_idx_order", {76'd0, idx_q[i]}, 7 - i);

        // ---- table vectors ----
        vecs[0] = '{4'd0, 80'h3FFF_8000000000000000, 0, 24, 1'b0};
        vecs[1] = '{4'd1, 80'h3FFE_8000000000000000, 0, 32, 1'b0};
        vecs[2] = '{4'd2, 80'h1234_5678_9ABC_DEF0_1234, 0, 1, 1'b1};
        vecs[3] = '{4'd15, 80'hFFFF_0000_FFFF_0000_FFFF, 0, 1, 1'b1};
        vecs[4] = '{4'd0, 80'h4000_C000000000000000, 10, 134, 1'b0};
        vecs[5] = '{4'd1, 80'h3FFD_A000000000000000, 2, 62, 1'b0};
        for (int v = 0; v < 6; v++) begin
            run(vecs[v].sel, vecs[v].x, vecs[v].st, lat, res, err);
            chk("vec_latency", lat, vecs[v].exp_lat);
            chk("vec_error", {79'd0, err}, {79'd0, vecs[v].exp_err});
            chk("vec_result", res, vecs[v].exp_err ? 80'd0 : horner(vecs[v].sel, vecs[v].x));
            if (vecs[v].exp_err) chk("vec_no_req", n_mul + n_add, 0);
        end

        // ---- unsupported selector: busy for exactly one cycle ----
        @(negedge clk);
        start = 1'b1;
        poly_select = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        chk("bad_busy_c1", {79'd0, busy}, 80'd1);
        chk("bad_done_c1", {79'd0, done}, 80'd1);
        @(posedge clk);
        #1;
        chk("bad_busy_c2", {79'd0, busy}, 80'd0);

        // ---- randomized runs ----
        for (int r = 0; r < 16; r++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
            check_run("rand", s, rand80(), $urandom_range(0, 3));
        end

        // ---- start pulsed while busy is ignored ----
        x1 = rand80();
        stall = 0;
        n_mul = 0;
        n_add = 0;
        @(negedge clk);
        start = 1'b1;
        poly_select = 4'd0;
        x_in = x1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        first_done = 0;
        res = 80'd0;
        for (cyc = 1; cyc < 60; cyc++) begin
            if (cyc == 10) begin
                start = 1'b1;
                poly_select = 4'd1;
                x_in = rand80();
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = cyc;
                    res = result;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("busy_start_done_pulses", n_done, 1);
        chk("busy_start_latency", first_done, 24);
        chk("busy_start_result", res, horner(4'd0, x1));
        chk("busy_start_held", result, horner(4'd0, x1));
        chk("busy_start_muls", n_mul, 6);

        // ---- reset in ADD_WAIT followed by a stray arith_done ----
        stall = 5;
        @(negedge clk);
        start = 1'b1;
        poly_select = 4'd0;
        x_in = rand80();
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!(pending && pend_op == 1'b0) && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("reach_add_wait", {79'd0, pending && pend_op == 1'b0}, 80'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        pending = 0;
        reset = 1'b0;
        chk("mid_rst_busy", {79'd0, busy}, 80'd0);
        chk("mid_rst_done", {79'd0, done}, 80'd0);
        chk("mid_rst_error", {79'd0, error}, 80'd0);
        chk("mid_rst_req", {79'd0, arith_req}, 80'd0);
        chk("mid_rst_op", {79'd0, arith_op}, 80'd0);
        chk("mid_rst_a", arith_a, 80'd0);
        chk("mid_rst_b", arith_b, 80'd0);
        chk("mid_rst_result", result, 80'd0);
        chk("mid_rst_rom_sel", {76'd0, rom_poly_select}, 80'd0);
        chk("mid_rst_rom_idx", {76'd0, rom_coeff_index}, 80'd0);
        inject_stray = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("stray_busy", {79'd0, busy}, 80'd0);
            chk("stray_done", {79'd0, done}, 80'd0);
        end
        check_run("after_reset", 4'd0, rand80(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
